// File: rtl/contadores_palabras.sv
// Word-counter bank for the four output FIFOs: per-FIFO accepted-POP counters,
// a modulo total counter, and a registered req/idx read port gated by idle.
module contadores_palabras #(
    parameter int CNT_W  = 5,
    parameter int N_FIFO = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Enable,
    input  logic              init,
    input  logic              idle,
    input  logic [N_FIFO-1:0] pop,
    input  logic [N_FIFO-1:0] empty,
    input  logic              req,
    input  logic [2:0]        idx,
    output logic [CNT_W-1:0]  data_out,
    output logic              valid
);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_COUNT,
        ST_READ
    } state_t;

    localparam logic [2:0] IDX_MAX = 3'(N_FIFO);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [N_FIFO+1];
    logic [CNT_W-1:0]   cnt_d [N_FIFO+1];
    logic [CNT_W-1:0]   data_q, data_d;
    logic               valid_q, valid_d;

    logic [N_FIFO-1:0]  accepted;
    logic [CNT_W-1:0]   total_inc;
    logic [CNT_W-1:0]   sel_cnt;
    logic               rd_ok;

    always_comb begin
        accepted  = pop & ~empty;
        total_inc = '0;
        for (int unsigned i = 0; i < N_FIFO; i++) begin
            total_inc = total_inc + CNT_W'(accepted[i]);
        end
    end

    // Snapshot comes from the registered counters, so pops accepted in the
    // request cycle are not part of the returned value.
    always_comb begin
        sel_cnt = '0;
        for (int unsigned i = 0; i <= N_FIFO; i++) begin
            if (idx == 3'(i)) begin
                sel_cnt = cnt_q[i];
            end
        end
    end

    assign rd_ok = req && idle && !init && (idx <= IDX_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (Enable) begin
            case (state_q)
                ST_CLEAR: begin
                    for (int unsigned i = 0; i <= N_FIFO; i++) begin
                        cnt_d[i] = '0;
                    end
                    valid_d = 1'b0;
                    if (!init) begin
                        state_d = ST_COUNT;
                    end
                end
                ST_COUNT, ST_READ: begin
                    if (init) begin
                        for (int unsigned i = 0; i <= N_FIFO; i++) begin
                            cnt_d[i] = '0;
                        end
                        valid_d = 1'b0;
                        state_d = ST_CLEAR;
                    end else begin
                        for (int unsigned i = 0; i < N_FIFO; i++) begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(accepted[i]);
                        end
                        cnt_d[N_FIFO] = cnt_q[N_FIFO] + total_inc;
                        if (rd_ok) begin
                            state_d = ST_READ;
                            valid_d = 1'b1;
                            data_d  = sel_cnt;
                        end else begin
                            state_d = ST_COUNT;
                            valid_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = ST_CLEAR;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '{default: '0};
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;

endmodule
